seq_restoring_divider: RTL and testbench
========================================

# seq_restoring_divider

Sequential N-bit unsigned restoring divider. It is the inverse-direction companion to the team's Vedic multiplier datapath and produces the quotient and remainder of an N-by-N division. It retires one quotient bit per clock using an (N+1)-bit ripple subtractor built from the existing `full_adder` cells, with the carry-in tied to 1 and the divisor inverted. It sits beside the multiplier as a multi-cycle arithmetic unit with a start/done handshake.

## Interface
- `N`, default 16: operand, quotient and remainder width; legal range 4..48.

- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  request a division; sampled only in IDLE or DONE
- `dividend`  input  N  unsigned dividend; sampled on the accepting edge only
- `divisor`  input  N  unsigned divisor; sampled on the accepting edge only
- `busy`  output  1  high while iterating
- `done`  output  1  one-cycle pulse when the results become valid
- `quotient`  output  N  result quotient, registered
- `remainder`  output  N  result remainder, registered
- `div_by_zero`  output  1  high alongside the results when the divisor was 0

## Operation
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; `busy`, `done`, `quotient`, `remainder` and `div_by_zero` are all 0; iteration counter is 0.
- States:
  - IDLE
  - RUN
  - DONE (lasts exactly one cycle)
- IDLE→RUN: on `start`=1.
  - Latch the dividend into the shift register Q.
  - Latch the divisor into register D.
  - Clear the (N+1)-bit partial remainder R.
  - Set the counter to N−1.
- RUN iteration, one per cycle:
  - R' = {R[N−1:0], Q[N−1]}.
  - T = R' − {1'b0, D} via the ripple subtractor.
  - If T is non-negative (subtractor carry-out = 1): R←T and shift 1 into Q[0].
  - Otherwise: R←R' and shift 0 into Q[0].
  - Q shifts left one bit per iteration.
- RUN→DONE: on the iteration where counter=0.
  - `quotient`←final Q.
  - `remainder`←final R[N−1:0].
  - `div_by_zero`←(D==0).
- DONE→IDLE: default.
- DONE→RUN: if `start`=1 in the DONE cycle. Back-to-back operation is legal.
- Divisor 0 needs no special datapath. Every trial subtraction succeeds, so the natural result is `quotient`=all ones and `remainder`=dividend. `div_by_zero` flags the case.
- `start` in RUN is ignored. Operands are not re-sampled and no error is raised.
- Result registers hold their values from DONE until the next result is written. They are not cleared on accept.
- Reset during RUN or DONE:
  - Aborts the operation; no `done` pulse is issued.
  - All outputs return to reset values on the next edge.
- Reset has priority over `start` in the same cycle.
- Width rules:
  - R is N+1 bits internally; the subtractor is N+1 bits.
  - Final R is always < D when D≠0, so truncation to N bits is lossless.

## Timing
- Let edge k be the rising edge that samples `start`=1 in IDLE or DONE.
- `busy`=1 from cycle k+1 through cycle k+N; iterations complete on edges k+1 … k+N.
- `done`=1 and `busy`=0 in cycle k+N+1, for exactly one cycle.
- Results are valid from cycle k+N+1 onward.
- Latency is N+1 cycles from start to done. Throughput is one division per N+1 cycles when `start` is re-asserted in each DONE cycle.
- `done` and `busy` are never high in the same cycle.
- `start`, `dividend` and `divisor` need only be valid at edge k.

## Configuration
- Macro: `DIV_ZERO_FAST_EN`.
- Defined:
  - If `divisor`==0 at edge k, the block goes IDLE/DONE→DONE directly.
  - `done`=1 in cycle k+1; `busy` never asserts.
  - Results: `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1.
- Undefined:
  - Divide-by-zero runs the full N iterations, with `done` in cycle k+N+1.
  - Result values and `div_by_zero` are identical to the defined case.
- Non-zero divisors behave identically in both builds.

## Test plan
1. N=16, dividend=100, divisor=7, `start` at edge k → `busy` in cycles k+1..k+16; `done` in cycle k+17; `quotient`=14, `remainder`=2, `div_by_zero`=0.
2. dividend=0xFFFF, divisor=1 → `quotient`=0xFFFF, `remainder`=0. Then, as a new division, dividend=5, divisor=9 → `quotient`=0, `remainder`=5.
3. dividend=0x1234, divisor=0 → `quotient`=0xFFFF, `remainder`=0x1234, `div_by_zero`=1. `done` at k+17 without `DIV_ZERO_FAST_EN`; `done` at k+1 with it and `busy` stays 0.
4. `start` pulsed with 50/3 at cycle k+5 while busy with 100/7 → ignored; result is 14/2 at k+17 and no second `done` follows.
5. Re-assert `start` with 1000/33 in the DONE cycle of test 1 → second `done` 17 cycles later with `quotient`=30, `remainder`=10.
6. Assert `rst` at cycle k+8 of a run → all outputs 0 the next cycle; no `done` appears; a fresh `start` afterwards produces correct results.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: N-bit unsigned restoring divider, one quotient bit per clock; define DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle
module seq_restoring_divider #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(N);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0] q, d, r, t;
  logic [N:0] r_sh;
  logic [N+1:0] c;
  logic accept, zero_fast, last, ge;
  assign accept = start && state != RUN;
`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = divisor == '0;
`else
  assign zero_fast = 1'b0;
`endif
  assign last = state == RUN && cnt == '0;
  assign r_sh = {r, q[N-1]};
  assign c[0] = 1'b1;
  // ripple subtract r_sh - {0,d}: full-adder cells with the divisor inverted
  for (genvar i = 0; i < N; i++) begin : g_sub
    assign t[i] = r_sh[i] ^ ~d[i] ^ c[i];
    assign c[i+1] = (r_sh[i] & ~d[i]) | (c[i] & (r_sh[i] ^ ~d[i]));
  end
  // top cell subtracts the zero-extension bit; only its carry (the sign) is needed
  assign c[N+1] = r_sh[N] | c[N];
  assign ge = c[N+1];
  always_comb begin
    state_nx = accept ? (zero_fast ? DONE : RUN) : last ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      q <= '0;
      d <= '0;
      r <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q <= dividend;
      d <= divisor;
      r <= '0;
      cnt <= CW'(N - 1);
      if (zero_fast) begin
        quotient <= '1;
        remainder <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      r <= ge ? t : r_sh[N-1:0];
      q <= {q[N-2:0], ge};
      cnt <= cnt - 1'b1;
      if (last) begin
        quotient <= {q[N-2:0], ge};
        remainder <= ge ? t : r_sh[N-1:0];
        div_by_zero <= d == '0;
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench for the restoring divider (N=16)
module tb_seq_restoring_divider;
  localparam int N = 16;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = N + 1;
`endif
  logic clk = 0, rst = 1, start = 0;
  logic [N-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic z;
    int lat;
    int k;
  } exp_t;
  exp_t sb[$];

  seq_restoring_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called at a negedge; start is sampled on the following posedge
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit accept = 1);
    exp_t e;
    dividend = a;
    divisor = b;
    start = 1;
    if (accept) begin
      e.q = (b == 0) ? '1 : a / b;
      e.r = (b == 0) ? a : a % b;
      e.z = b == 0;
      e.lat = (b == 0) ? ZLAT : N + 1;
      e.k = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * N && sb.size() > 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("busy_with_done", busy, 0);
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("latency", cyc - e.k, e.lat);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_by_zero, 0);
    // 100/7 with busy window, then back-to-back 1000/33 in its DONE cycle
    issue(100, 7);
    chk("busy_first", busy, 1);
    repeat (N - 1) @(negedge clk);
    chk("busy_last", busy, 1);
    chk("done_early", done, 0);
    @(negedge clk);
    chk("done_cycle", done, 1);
    issue(1000, 33);
    drain();
    issue(16'hFFFF, 1);
    drain();
    issue(5, 9);
    drain();
    issue(16'h1234, 0);
    chk("zero_busy", busy, ZLAT == 1 ? 0 : 1);
    drain();
    // start during RUN is ignored
    issue(100, 7);
    repeat (4) @(negedge clk);
    issue(50, 3, 0);
    drain();
    repeat (N + 4) @(negedge clk);
    // reset mid-run aborts without a done pulse
    issue(100, 7);
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_z", div_by_zero, 0);
    repeat (N + 4) @(negedge clk);
    issue(1000, 33);
    drain();
    for (int i = 0; i < 10; i++) begin
      issue(N'($urandom), (i % 5 == 4) ? '0 : N'($urandom_range(1, (i % 2) ? 255 : 65535)));
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
